seq_div: RTL

Iterative radix-2 integer divider producing quotient and remainder over BW cycles, with selectable signed/unsigned mode. It is the multi-cycle counterpart to the single-cycle add/subtract datapath: each iteration performs one trial subtraction of the divisor from the partial remainder. It sits beside the ALU as a long-latency execution unit behind a Start/Done handshake.

---
 rtl/seq_div.sv | 131 +++++++++++++
 1 files changed

// File: rtl/seq_div.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle, MSB first.
// Signed mode divides magnitudes and then fixes the signs of quotient and remainder.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | waiting for start; operands captured on acceptance
// S_CALC | one trial subtraction per edge until the counter reaches zero
// S_FIX  | apply result signs (or divide-by-zero values), register outputs
// S_DONE | one-cycle done pulse, then back to idle
module seq_div #(
  parameter int BW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          signed_mode,
  input  logic [BW-1:0] dividend,
  input  logic [BW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [BW-1:0] quotient,
  output logic [BW-1:0] remainder,
  output logic          div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state;
  logic [BW-1:0] r_q;
  logic [BW-1:0] q_q;
  logic [BW-1:0] d_q;
  logic [BW-1:0] cnt_q;
  logic          q_neg_q;
  logic          r_neg_q;
  logic          dbz_q;

  logic          dvd_neg;
  logic          dvs_neg;
  logic [BW-1:0] dvd_mag;
  logic [BW-1:0] dvs_mag;
  logic [BW:0]   r_sh;
  logic [BW:0]   trial;
  logic          take;

  assign dvd_neg = signed_mode & dividend[BW-1];
  assign dvs_neg = signed_mode & divisor[BW-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor : divisor;

  // The partial remainder is always below the divisor, so the shifted value
  // fits in BW+1 bits and the trial difference's top bit is its sign.
  assign r_sh  = {r_q, q_q[BW-1]};
  assign trial = r_sh - {1'b0, d_q};
  assign take  = ~trial[BW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dbz_q       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy    <= 1'b1;
            d_q     <= dvs_mag;
            q_neg_q <= dvd_neg ^ dvs_neg;
            r_neg_q <= dvd_neg;
            if (divisor == '0) begin
              // Raw dividend is kept so the remainder reports it unmodified.
              dbz_q <= 1'b1;
              r_q   <= dividend;
              q_q   <= '0;
              state <= S_FIX;
            end else begin
              dbz_q <= 1'b0;
              r_q   <= '0;
              q_q   <= dvd_mag;
              cnt_q <= BW'(BW);
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (cnt_q == '0) begin
            state <= S_FIX;
          end else begin
            r_q   <= take ? trial[BW-1:0] : r_sh[BW-1:0];
            q_q   <= {q_q[BW-2:0], take};
            cnt_q <= cnt_q - BW'(1);
          end
        end
        S_FIX: begin
          if (dbz_q) begin
            quotient  <= '1;
            remainder <= r_q;
          end else begin
            quotient  <= q_neg_q ? -q_q : q_q;
            remainder <= r_neg_q ? -r_q : r_q;
          end
          div_by_zero <= dbz_q;
          busy        <= 1'b0;
          done        <= 1'b1;
          state       <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
